// File: rtl/psum_combine_norm.sv
// psum_combine_norm: fuses adjacent psum lanes (x1/x2/x4), saturates each
// fused lane to ob bits, reports the row abs-sum and optionally normalises
// every lane by that sum with a parallel restoring divider (frac+1 cycles).
module psum_combine_norm #(
    parameter int col     = 8,
    parameter int bw      = 4,
    parameter int bw_psum = 12,
    parameter int ob      = 24,
    parameter int frac    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   mode,
    input  logic                         norm_en,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [col*bw_psum-1:0]       in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [col*ob-1:0]            out_data,
    output logic [ob+$clog2(col)-1:0]    out_sum,
    output logic                         out_dz
);

    localparam int SW = ob + $clog2(col);        // abs-sum width, cannot overflow
    localparam int FW = bw_psum + 3*bw;          // nominal fused width
    // Two guard bits keep the x4 fusion exact before saturation.
    localparam int WW = (FW + 2 > ob + 1) ? FW + 2 : ob + 1;
    localparam int CW = $clog2(frac + 1) + 1;

    localparam logic [WW-1:0] SMAX = {{(WW-ob+1){1'b0}}, {(ob-1){1'b1}}};
    localparam logic [WW-1:0] SMIN = ~SMAX;

    typedef enum logic [1:0] {IDLE, COMB, DIV, OUT} state_t;

    state_t                          state_q, state_d;
    logic [col-1:0][bw_psum-1:0]     lanes_q, lanes_d;
    logic [1:0]                      mode_q, mode_d;
    logic                            norm_q, norm_d;
    logic [col-1:0][ob-1:0]          res_q, res_d;
    logic [SW-1:0]                   sum_q, sum_d;
    logic                            dz_q, dz_d;
    logic [col-1:0][SW:0]            rem_q, rem_d;
    logic [col-1:0]                  neg_q, neg_d;
    logic [col-1:0][frac:0]          quo_q, quo_d;
    logic [CW-1:0]                   cnt_q, cnt_d;

    logic [col-1:0][WW-1:0]          grp;
    logic [col-1:0][ob-1:0]          sat;
    logic [col-1:0][SW-1:0]          absv;
    logic [SW-1:0]                   sumc;
    logic [col-1:0][SW:0]            rem_n;
    logic [col-1:0][frac:0]          quo_n;
    logic [col-1:0][ob-1:0]          qfin;
    logic                            last_div;

    function automatic logic [WW-1:0] sx(input logic [bw_psum-1:0] v);
        return {{(WW-bw_psum){v[bw_psum-1]}}, v};
    endfunction

    // State and datapath registers; reset drops any row in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lanes_q <= '0;
            mode_q  <= '0;
            norm_q  <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            dz_q    <= 1'b0;
            rem_q   <= '0;
            neg_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lanes_q <= lanes_d;
            mode_q  <= mode_d;
            norm_q  <= norm_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            dz_q    <= dz_d;
            rem_q   <= rem_d;
            neg_q   <= neg_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign last_div = (cnt_q == CW'(frac));

    // Next-state: IDLE -> COMB -> (DIV x frac+1) -> OUT -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid)  state_d = COMB;
            COMB: state_d = norm_q ? DIV : OUT;
            DIV:  if (last_div)  state_d = OUT;
            OUT:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane fusion, saturation and abs-sum of the latched row.
    always_comb begin
        grp = '0;
        case (mode_q)
            2'd1: for (int k = 0; k < col/2; k++)
                      grp[k] = sx(lanes_q[2*k]) + (sx(lanes_q[2*k+1]) << bw);
            2'd2: for (int k = 0; k < col/4; k++)
                      for (int j = 0; j < 4; j++)
                          grp[k] = grp[k] + (sx(lanes_q[4*k+j]) << (j*bw));
            default: for (int k = 0; k < col; k++)
                      grp[k] = sx(lanes_q[k]);
        endcase
        sumc = '0;
        for (int k = 0; k < col; k++) begin
            if ($signed(grp[k]) > $signed(SMAX))      sat[k] = SMAX[ob-1:0];
            else if ($signed(grp[k]) < $signed(SMIN)) sat[k] = SMIN[ob-1:0];
            else                                      sat[k] = grp[k][ob-1:0];
            absv[k] = sat[k][ob-1] ? -{{(SW-ob){1'b1}}, sat[k]}
                                   :  {{(SW-ob){1'b0}}, sat[k]};
            sumc = sumc + absv[k];
        end
    end

    // One restoring step per lane; the first step has no pre-shift because |x| <= sum.
    always_comb begin
        for (int k = 0; k < col; k++) begin
            logic [SW:0] t;
            logic        b;
            logic [ob-1:0] qe;
            t = (cnt_q == '0) ? rem_q[k] : {rem_q[k][SW-1:0], 1'b0};
            b = (t >= {1'b0, sum_q});
            rem_n[k] = b ? t - {1'b0, sum_q} : t;
            quo_n[k] = {quo_q[k][frac-1:0], b};
            qe = {{(ob-frac-1){1'b0}}, quo_n[k]};
            if (sum_q == '0)   qfin[k] = '0;
            else if (neg_q[k]) qfin[k] = -qe;
            else               qfin[k] = qe;
        end
    end

    // Register next values per state.
    always_comb begin
        lanes_d = lanes_q;
        mode_d  = mode_q;
        norm_d  = norm_q;
        res_d   = res_q;
        sum_d   = sum_q;
        dz_d    = dz_q;
        rem_d   = rem_q;
        neg_d   = neg_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (in_valid) begin
                lanes_d = in_data;
                mode_d  = mode;
                norm_d  = norm_en;
                dz_d    = 1'b0;
            end
            COMB: begin
                res_d = sat;
                sum_d = sumc;
                dz_d  = norm_q && (sumc == '0);
                for (int k = 0; k < col; k++) begin
                    rem_d[k] = {1'b0, absv[k]};
                    neg_d[k] = sat[k][ob-1];
                end
                quo_d = '0;
                cnt_d = '0;
            end
            DIV: begin
                rem_d = rem_n;
                quo_d = quo_n;
                cnt_d = cnt_q + 1'b1;
                if (last_div) res_d = qfin;
            end
            default: ;
        endcase
    end

    // Outputs decoded from state and result registers.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == OUT);
        out_data  = res_q;
        out_sum   = sum_q;
        out_dz    = dz_q;
    end

endmodule
